// File: rtl/perceptron_predict_train.sv
// -----------------------------------------------------------------------------
// perceptron_predict_train
//
// Front-end controller for the perceptron weight table. It drives the table
// read index, sums the returned weights against the committed global history,
// and emits a taken/not-taken prediction three cycles after the request is
// accepted. Every prediction is parked in a small FIFO until the branch unit
// resolves it. On resolution the controller decides whether to train and, if
// so, drives the table's update port for one cycle.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Ready never depends on valid. An offered request or
// resolution is held until accepted. pred_valid is an output-only pulse and
// has no back-pressure.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   req_valid     prediction request
//   req_pc        branch PC
//   req_ready     request accepted when req_valid & req_ready
//   pred_valid    one-cycle prediction pulse
//   pred_taken    1 = taken (y >= 0)
//   pred_y        signed perceptron output
//   res_valid     resolution of the oldest outstanding prediction
//   res_taken     actual branch direction
//   res_ready     resolution accepted when res_valid & res_ready
//   rdIdx         table read index (combinational from req_pc)
//   weights_in    table read data for rdIdx, same cycle, 9-bit 2's complement
//   write         table update strobe (one cycle per training event)
//   wrIdx         table update index
//   ghr           history snapshot for the update (bit k trains weight k)
//   br_outcome    actual outcome for the update
//
// Optional feature macro: PERC_STATS_EN
//   When defined, adds saturating 32-bit counters stat_pred, stat_mispred
//   and stat_train. When undefined, these ports and counters do not exist.
// -----------------------------------------------------------------------------
module perceptron_predict_train #(
  parameter int WEIGHT_NUM = 33,
  parameter int IDX_BITS   = 12,
  parameter int THETA      = 75,
  parameter int INFL_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic [31:0]             req_pc,
  output logic                    req_ready,
  output logic                    pred_valid,
  output logic                    pred_taken,
  output logic [15:0]             pred_y,
  input  logic                    res_valid,
  input  logic                    res_taken,
  output logic                    res_ready,
  output logic [IDX_BITS-1:0]     rdIdx,
  input  logic [WEIGHT_NUM*9-1:0] weights_in,
  output logic                    write,
  output logic [IDX_BITS-1:0]     wrIdx,
  output logic [31:0]             ghr,
  output logic                    br_outcome
`ifdef PERC_STATS_EN
  ,
  output logic [31:0]             stat_pred,
  output logic [31:0]             stat_mispred,
  output logic [31:0]             stat_train
`endif
);

  // History terms pair with weights 0..HIST_BITS-1; the last weight is bias.
  localparam int HIST_BITS = WEIGHT_NUM - 1;
  // Adder tree is split into three groups of (up to) eleven terms.
  localparam int NGRP      = 3;
  localparam int GRP       = (WEIGHT_NUM + NGRP - 1) / NGRP;
  localparam int PTR_W     = $clog2(INFL_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int SUM_W     = CNT_W + 1;

  // ---------------------------------------------------------------------------
  // Committed history and request acceptance
  // ---------------------------------------------------------------------------
  logic [31:0]      hist;
  logic [CNT_W-1:0] fifo_count;
  logic [SUM_W-1:0] inflight;
  logic             accept;
  logic             pop;

  logic             s1_valid;
  logic             s2_valid;

  // Everything accepted but not yet resolved: pipeline stages plus FIFO.
  // pred_valid counts as in-pipeline; its FIFO push lands at the next edge.
  always_comb begin
    inflight = SUM_W'(fifo_count) + SUM_W'(s1_valid) + SUM_W'(s2_valid)
             + SUM_W'(pred_valid);
  end

  assign req_ready = ~rst & (inflight < SUM_W'(INFL_DEPTH));
  assign accept    = req_valid & req_ready;
  // Read index is forced to zero while reset is held so the table port idles.
  assign rdIdx     = rst ? '0 : req_pc[IDX_BITS+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{req_pc[31:IDX_BITS+2], req_pc[1:0]};

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  logic [WEIGHT_NUM*9-1:0] s1_w;
  logic [31:0]             s1_hist;
  logic [IDX_BITS-1:0]     s1_idx;

  logic signed [15:0]      psum_d [NGRP];
  logic signed [15:0]      s2_psum [NGRP];
  logic [31:0]             s2_hist;
  logic [IDX_BITS-1:0]     s2_idx;

  logic signed [15:0]      y_d;
  logic [IDX_BITS-1:0]     pred_idx;
  logic [31:0]             pred_hist;

  // Signed contribution of one history-paired weight.
  function automatic logic signed [15:0] weight_term(input logic [8:0] w,
                                                     input logic       pos);
    logic signed [15:0] ext;
    ext = {{7{w[8]}}, w};
    return pos ? ext : -ext;
  endfunction

  // Stage 1: three partial sums; bias weight is always added positively and
  // belongs to the last group.
  always_comb begin
    for (int g = 0; g < NGRP; g++) begin
      psum_d[g] = '0;
    end
    for (int k = 0; k < HIST_BITS; k++) begin
      psum_d[k / GRP] = psum_d[k / GRP] + weight_term(s1_w[9*k +: 9], s1_hist[k]);
    end
    psum_d[NGRP-1] = psum_d[NGRP-1]
                   + {{7{s1_w[9*HIST_BITS + 8]}}, s1_w[9*HIST_BITS +: 9]};
  end

  // Stage 2: final sum. Range is bounded by 33*256, so 16 bits never wrap.
  always_comb begin
    y_d = s2_psum[0] + s2_psum[1] + s2_psum[2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_w       <= '0;
      s1_hist    <= '0;
      s1_idx     <= '0;
      s2_valid   <= 1'b0;
      s2_psum    <= '{default: '0};
      s2_hist    <= '0;
      s2_idx     <= '0;
      pred_valid <= 1'b0;
      pred_y     <= '0;
      pred_taken <= 1'b0;
      pred_idx   <= '0;
      pred_hist  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_w    <= weights_in;
        s1_hist <= hist;
        s1_idx  <= rdIdx;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_psum <= psum_d;
        s2_hist <= s1_hist;
        s2_idx  <= s1_idx;
      end
      pred_valid <= s2_valid;
      if (s2_valid) begin
        pred_y     <= y_d;
        pred_taken <= ~y_d[15];
        pred_idx   <= s2_idx;
        pred_hist  <= s2_hist;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outstanding-prediction FIFO
  // ---------------------------------------------------------------------------
  logic [IDX_BITS-1:0] fifo_idx  [INFL_DEPTH];
  logic [31:0]         fifo_hist [INFL_DEPTH];
  logic [15:0]         fifo_y    [INFL_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic                push;

  assign push      = pred_valid;
  // Based on the registered count, so an entry pushed this cycle is not
  // visible to the resolve side until the next cycle.
  assign res_ready = (fifo_count != '0);
  assign pop       = res_valid & res_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr]  <= pred_idx;
      fifo_hist[wr_ptr] <= pred_hist;
      fifo_y[wr_ptr]    <= pred_y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Resolution: training decision and table update port
  // ---------------------------------------------------------------------------
  logic [15:0] head_y;
  logic [15:0] head_abs;
  logic        mispred;
  logic        train;

  always_comb begin
    head_y   = fifo_y[rd_ptr];
    head_abs = head_y[15] ? 16'(-head_y) : head_y;
    mispred  = (~head_y[15]) != res_taken;
    train    = mispred | (head_abs <= 16'(THETA));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist       <= '0;
      write      <= 1'b0;
      wrIdx      <= '0;
      ghr        <= '0;
      br_outcome <= 1'b0;
    end else begin
      write <= pop & train;
      if (pop) begin
        hist <= {hist[30:0], res_taken};
      end
      // Update fields hold their last values when no training happens.
      if (pop && train) begin
        wrIdx      <= fifo_idx[rd_ptr];
        ghr        <= fifo_hist[rd_ptr];
        br_outcome <= res_taken;
      end
    end
  end

`ifdef PERC_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating statistics counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_pred    <= '0;
      stat_mispred <= '0;
      stat_train   <= '0;
    end else begin
      if (pred_valid && (stat_pred != '1))
        stat_pred <= stat_pred + 32'd1;
      if (pop && mispred && (stat_mispred != '1))
        stat_mispred <= stat_mispred + 32'd1;
      if (pop && train && (stat_train != '1))
        stat_train <= stat_train + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_perceptron_predict_train.sv
module tb_perceptron_predict_train;

  localparam int WN = 33;
  localparam int WW = WN * 9;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic [31:0]   req_pc = '0;
  logic          res_valid = 1'b0;
  logic          res_taken = 1'b0;
  logic [WW-1:0] weights_in = '0;

  logic          req_ready;
  logic          pred_valid;
  logic          pred_taken;
  logic [15:0]   pred_y;
  logic          res_ready;
  logic [11:0]   rdIdx;
  logic          write;
  logic [11:0]   wrIdx;
  logic [31:0]   ghr;
  logic          br_outcome;
`ifdef PERC_STATS_EN
  logic [31:0]   stat_pred;
  logic [31:0]   stat_mispred;
  logic [31:0]   stat_train;
`endif

  always #5 clk = ~clk;

  perceptron_predict_train dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_pc     (req_pc),
    .req_ready  (req_ready),
    .pred_valid (pred_valid),
    .pred_taken (pred_taken),
    .pred_y     (pred_y),
    .res_valid  (res_valid),
    .res_taken  (res_taken),
    .res_ready  (res_ready),
    .rdIdx      (rdIdx),
    .weights_in (weights_in),
    .write      (write),
    .wrIdx      (wrIdx),
    .ghr        (ghr),
    .br_outcome (br_outcome)
`ifdef PERC_STATS_EN
    ,
    .stat_pred    (stat_pred),
    .stat_mispred (stat_mispred),
    .stat_train   (stat_train)
`endif
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];   // expected pred_y, in order
  logic [44:0] wexp_q[$];  // expected {wrIdx, ghr, br_outcome}
  logic [59:0] mdl_q[$];   // outstanding {idx, snapshot, y}
  logic [31:0] mdl_h = '0; // reference committed history

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_y(input logic [WW-1:0] w,
                                          input logic [31:0]   h);
    int s;
    logic signed [8:0] wk;
    s = 0;
    for (int k = 0; k < 32; k++) begin
      wk = w[9*k +: 9];
      s  = h[k] ? s + int'(wk) : s - int'(wk);
    end
    wk = w[9*32 +: 9];
    s  = s + int'(wk);
    return s[15:0];
  endfunction

  function automatic logic [WW-1:0] make_w(input logic [8:0] others,
                                           input logic [8:0] bias);
    logic [WW-1:0] w;
    for (int k = 0; k < 32; k++) w[9*k +: 9] = others;
    w[9*32 +: 9] = bias;
    return w;
  endfunction

  // Output monitor: compares every prediction and every table write in order.
  always @(negedge clk) begin
    if (!rst) begin
      if (pred_valid) begin
        if (exp_q.size() == 0) begin
          check("pred_unexpected", 64'd1, 64'd0);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check("pred_y", {48'd0, pred_y}, {48'd0, e});
          check("pred_taken", {63'd0, pred_taken}, {63'd0, ~e[15]});
        end
      end
      if (write) begin
        if (wexp_q.size() == 0) begin
          check("write_unexpected", 64'd1, 64'd0);
        end else begin
          logic [44:0] we;
          we = wexp_q.pop_front();
          check("write_fields", {19'd0, wrIdx, ghr, br_outcome}, {19'd0, we});
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    wexp_q.delete();
    mdl_q.delete();
    mdl_h = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_req(input logic [31:0] pc, input logic [WW-1:0] w);
    logic [15:0] y;
    logic [11:0] idx;
    idx        = pc[13:2];
    req_valid  = 1'b1;
    req_pc     = pc;
    weights_in = w;
    #1;
    check("req_ready", {63'd0, req_ready}, 64'd1);
    check("rdIdx", {52'd0, rdIdx}, {52'd0, idx});
    y = model_y(w, mdl_h);
    exp_q.push_back(y);
    mdl_q.push_back({idx, mdl_h, y});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_res(input logic taken);
    int          n;
    logic [59:0] m;
    logic [15:0] y;
    logic [15:0] a;
    logic        mis;
    logic        trn;
    n = 0;
    while (!res_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("res_ready_wait", {63'd0, res_ready}, 64'd1);
    if (res_ready) begin
      res_valid = 1'b1;
      res_taken = taken;
      m   = mdl_q.pop_front();
      y   = m[15:0];
      mis = (~y[15]) != taken;
      a   = y[15] ? -y : y;
      trn = mis || (a <= 16'd75);
      if (trn) wexp_q.push_back({m[59:48], m[47:16], taken});
      mdl_h = {mdl_h[30:0], taken};
      @(negedge clk);
      res_valid = 1'b0;
      res_taken = 1'b0;
    end
  endtask

  task automatic wait_pred();
    int n;
    n = 0;
    while (!pred_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("pred_wait", {63'd0, pred_valid}, 64'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [WW-1:0] wsp;

    // Reset state
    #1;
    check("rst_req_ready", {63'd0, req_ready}, 64'd0);
    do_reset();
    check("rst_req_ready_after", {63'd0, req_ready}, 64'd1);
    check("rst_pred_valid", {63'd0, pred_valid}, 64'd0);
    check("rst_res_ready", {63'd0, res_ready}, 64'd0);
    check("rst_write", {63'd0, write}, 64'd0);
    check("rst_pred_y", {48'd0, pred_y}, 64'd0);
    check("rst_ghr", {32'd0, ghr}, 64'd0);

    // Test 1: zero weights, latency T+3, train on mispredict
    do_req(32'h100, make_w(9'd0, 9'd0));
    check("t1_rdidx", {52'd0, dut.s1_idx}, 64'h040);
    check("t1_lat_t1", {63'd0, pred_valid}, 64'd0);
    @(negedge clk);
    check("t1_lat_t2", {63'd0, pred_valid}, 64'd0);
    @(negedge clk);
    check("t1_lat_t3", {63'd0, pred_valid}, 64'd1);
    check("t1_y", {48'd0, pred_y}, 64'd0);
    check("t1_taken", {63'd0, pred_taken}, 64'd1);
    do_res(1'b0);
    check("t1_write", {63'd0, write}, 64'd1);
    check("t1_wridx", {52'd0, wrIdx}, 64'h040);
    check("t1_ghr", {32'd0, ghr}, 64'd0);
    check("t1_outcome", {63'd0, br_outcome}, 64'd0);
`ifdef PERC_STATS_EN
    check("t1_stat_pred", {32'd0, stat_pred}, 64'd1);
    check("t1_stat_mispred", {32'd0, stat_mispred}, 64'd1);
    check("t1_stat_train", {32'd0, stat_train}, 64'd1);
`endif
    @(negedge clk);
    check("t1_write_pulse", {63'd0, write}, 64'd0);

    // Test 2: confident correct prediction does not train
    do_req(32'h204, make_w(9'd0, 9'd100));
    wait_pred();
    check("t2_y", {48'd0, pred_y}, 64'd100);
    do_res(1'b1);
    check("t2_no_write", {63'd0, write}, 64'd0);
    do_idle(2);

    // Test 3: threshold boundary
    do_req(32'h308, make_w(9'd0, 9'd75));
    do_res(1'b1);
    check("t3_write_75", {63'd0, write}, 64'd1);
    do_req(32'h30C, make_w(9'd0, 9'd76));
    do_res(1'b1);
    check("t3_no_write_76", {63'd0, write}, 64'd0);
    do_idle(2);

    // Test 4: history all ones via 32 taken resolves, then all zeros
    do_reset();
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        do_req($urandom_range(0, 32'hFFFF_FFFF), make_w(9'd0, 9'd0));
      end
      for (int i = 0; i < 8; i++) do_res(1'b1);
    end
    do_req(32'h40C, make_w(9'd1, 9'd1));
    wait_pred();
    check("t4_y_pos", {48'd0, pred_y}, 64'd33);
    do_res(1'b1);
    do_reset();
    do_req(32'h510, make_w(9'd1, 9'd1));
    wait_pred();
    check("t4_y_neg", {48'd0, pred_y}, 64'hFFE1);
    check("t4_taken_neg", {63'd0, pred_taken}, 64'd0);
    do_res(1'b0);
    do_idle(2);

    // Test 5: capacity limit and history snapshot
    do_reset();
    for (int i = 0; i < 8; i++) do_req(32'h1000 + 32'(i * 4), make_w(9'd0, 9'd0));
    check("t5_full", {63'd0, req_ready}, 64'd0);
    do_res(1'b1);
    check("t5_ready_again", {63'd0, req_ready}, 64'd1);
    do_res(1'b0);
    do_res(1'b1);
    wsp = '0;
    wsp[0 +: 9]  = 9'd10;
    wsp[9 +: 9]  = 9'd20;
    wsp[18 +: 9] = 9'd40;
    wsp[27 +: 9] = 9'd80;
    do_req(32'h614, wsp);
    wait_pred();
    check("t5_y_snap", {48'd0, pred_y}, 64'hFFCE);
    for (int i = 0; i < 5; i++) do_res(1'b0);
    do_res(1'b0);
    check("t5_write", {63'd0, write}, 64'd1);
    check("t5_ghr", {32'd0, ghr}, 64'h5);
    check("t5_wridx", {52'd0, wrIdx}, 64'h185);
    do_idle(2);

    // Test 6: reset with three requests in flight
    for (int i = 0; i < 3; i++) do_req(32'h700 + 32'(i * 4), make_w(9'd0, 9'd9));
    #2;
    rst = 1'b1;
    #1;
    check("t6_pred_valid", {63'd0, pred_valid}, 64'd0);
    check("t6_pred_y", {48'd0, pred_y}, 64'd0);
    check("t6_req_ready", {63'd0, req_ready}, 64'd0);
    check("t6_res_ready", {63'd0, res_ready}, 64'd0);
    check("t6_wridx", {52'd0, wrIdx}, 64'd0);
    check("t6_ghr", {32'd0, ghr}, 64'd0);
    exp_q.delete();
    wexp_q.delete();
    mdl_q.delete();
    mdl_h = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_idle(8);
    check("t6_res_ready_after", {63'd0, res_ready}, 64'd0);
    check("t6_write_after", {63'd0, write}, 64'd0);

    // Everything expected must have been observed
    check("end_pred_q_empty", 64'(exp_q.size()), 64'd0);
    check("end_write_q_empty", 64'(wexp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
